// File: rtl/pc_branch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_branch_ctrl
//
// Program-counter and branch-resolution stage. Each cycle it takes the
// single-bit flag/flip values from the upstream register block, plus the
// decoded control strobes, and computes the next instruction address. A
// three-state FSM (IDLE / RUN / DONE) sequences program start, execution and
// halt. A saturating counter tracks retired instructions.
//
// Parameters
//   PC_W   program counter / instruction address width
//   OFF_W  signed (two's complement) branch offset width
//   CNT_W  retired-instruction counter width
//
// Ports
//   CLK          clock; all state changes on its rising edge
//   reset        synchronous, active-high; overrides every other input
//   start        single-cycle pulse; begin execution at start_addr (IDLE/DONE)
//   start_addr   entry address, sampled together with start
//   stall        hold pc, counter and state; ignore all strobes this cycle
//   halt         halt instruction -> DONE, pc stays on the halt instruction
//   jump         unconditional absolute jump to jump_target
//   jump_target  absolute jump address
//   branch       conditional relative branch by offset
//   offset       signed displacement relative to the current pc
//   flag         flag bit from the upstream register block
//   flip         inverts the branch sense when 1
//   pc           current instruction address
//   running      high while in RUN
//   done         high while in DONE
//   insn_count   retired-instruction count (saturating)
// -----------------------------------------------------------------------------
module pc_branch_ctrl #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             stall,
    input  logic             halt,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch,
    input  logic [OFF_W-1:0] offset,
    input  logic             flag,
    input  logic             flip,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] insn_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;
    logic            taken;
    logic            cnt_sat;

    // Sign-extend the displacement to pc width; the add then wraps modulo
    // 2^PC_W naturally, which is the intended address-space behaviour.
    assign off_ext = PC_W'($signed(offset));
    assign pc_inc  = pc + PC_W'(1);
    assign pc_rel  = pc + off_ext;

    // flip selects branch-on-clear instead of branch-on-set.
    assign taken   = flag ^ flip;
    assign cnt_sat = &insn_count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            insn_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Only start is honoured outside RUN; pc and count hold.
                    if (start) begin
                        state      <= RUN;
                        pc         <= start_addr;
                        insn_count <= '0;
                        running    <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                RUN: begin
                    // A stalled cycle changes nothing, halt included.
                    if (!stall) begin
                        // Every retired instruction counts, the halt too.
                        if (!cnt_sat)
                            insn_count <= insn_count + CNT_W'(1);

                        if (halt) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (jump) begin
                            pc <= jump_target;
                        end else if (branch && taken) begin
                            pc <= pc_rel;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_ctrl
//
// Directed-vector bench for pc_branch_ctrl. A behavioural model (plain
// integers) tracks the architectural state; a negedge process compares the
// DUT to it every cycle, and directed steps add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_pc_branch_ctrl;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int CNT_W = 16;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             reset;
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             stall;
    logic             halt;
    logic             jump;
    logic [PC_W-1:0]  jump_target;
    logic             branch;
    logic [OFF_W-1:0] offset;
    logic             flag;
    logic             flip;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] insn_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: 0 = idle, 1 = run, 2 = done.
    int m_st  = 0;
    int m_pc  = 0;
    int m_cnt = 0;

    pc_branch_ctrl #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .reset(reset), .start(start), .start_addr(start_addr),
        .stall(stall), .halt(halt), .jump(jump), .jump_target(jump_target),
        .branch(branch), .offset(offset), .flag(flag), .flip(flip),
        .pc(pc), .running(running), .done(done), .insn_count(insn_count)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: evaluated from the rules on each rising edge.
    always @(posedge CLK) begin
        int soff;
        if (reset) begin
            m_st = 0; m_pc = 0; m_cnt = 0;
        end else if (m_st != 1) begin
            if (start) begin
                m_st = 1; m_pc = int'(start_addr); m_cnt = 0;
            end
        end else if (!stall) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            soff = int'(offset);
            if (soff >= (1 << (OFF_W - 1))) soff = soff - (1 << OFF_W);
            if (halt)
                m_st = 2;
            else if (jump)
                m_pc = int'(jump_target);
            else if (branch && (flag != flip))
                m_pc = ((m_pc + soff) % PC_MOD + PC_MOD) % PC_MOD;
            else
                m_pc = (m_pc + 1) % PC_MOD;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("model_pc",      int'(pc),         m_pc);
            chk("model_running", int'(running),    int'(m_st == 1));
            chk("model_done",    int'(done),       int'(m_st == 2));
            chk("model_count",   int'(insn_count), m_cnt);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; halt = 0; jump = 0; branch = 0;
        flag = 0; flip = 0; offset = '0; start_addr = '0; jump_target = '0;
    endtask

    task automatic do_jump(input int tgt);
        jump = 1; jump_target = PC_W'(tgt);
        tick();
        jump = 0;
    endtask

    logic [PC_W-1:0] br_exp [4];
    logic            br_flag [4];
    logic            br_flip [4];
    int              c0;

    initial begin
        idle_inputs();
        reset = 1;
        tick(2);
        reset = 0;
        cmp_en = 1;

        // 1. reset state, start, sequential steps
        chk("reset_pc", int'(pc), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_count", int'(insn_count), 0);
        tick();
        chk("idle_hold_pc", int'(pc), 0);
        start = 1; start_addr = 10'h010;
        tick();
        start = 0;
        chk("start_pc", int'(pc), 'h010);
        chk("start_running", int'(running), 1);
        tick(3);
        chk("step3_pc", int'(pc), 'h013);
        chk("step3_count", int'(insn_count), 3);

        // 2. branch with all flag/flip combinations, offset -4 from 0x020
        br_flag[0] = 1; br_flip[0] = 0; br_exp[0] = 10'h01C;
        br_flag[1] = 0; br_flip[1] = 0; br_exp[1] = 10'h021;
        br_flag[2] = 0; br_flip[2] = 1; br_exp[2] = 10'h01C;
        br_flag[3] = 1; br_flip[3] = 1; br_exp[3] = 10'h021;
        for (int i = 0; i < 4; i++) begin
            do_jump('h020);
            chk("jump_pc", int'(pc), 'h020);
            branch = 1; offset = 8'hFC; flag = br_flag[i]; flip = br_flip[i];
            tick();
            branch = 0; flag = 0; flip = 0;
            chk($sformatf("branch_ff%0d", i), int'(pc), int'(br_exp[i]));
        end

        // 3. wrap-around on increment and on negative offset
        do_jump('h3FF);
        tick();
        chk("wrap_inc", int'(pc), 'h000);
        do_jump('h002);
        branch = 1; offset = 8'h80; flag = 1;
        tick();
        branch = 0; flag = 0;
        chk("wrap_branch", int'(pc), 'h382);

        // 4. halt beats jump; restart from DONE
        do_jump('h040);
        c0 = int'(insn_count);
        halt = 1; jump = 1; jump_target = 10'h100; branch = 1; flag = 1;
        tick();
        halt = 0; jump = 0; branch = 0; flag = 0;
        chk("halt_pc", int'(pc), 'h040);
        chk("halt_done", int'(done), 1);
        chk("halt_running", int'(running), 0);
        chk("halt_count", int'(insn_count), c0 + 1);
        jump = 1; jump_target = 10'h1AB;
        tick(2);
        jump = 0;
        chk("done_hold_pc", int'(pc), 'h040);
        start = 1; start_addr = 10'h005;
        tick();
        start = 0;
        chk("restart_pc", int'(pc), 'h005);
        chk("restart_running", int'(running), 1);
        chk("restart_count", int'(insn_count), 0);

        // 5. stall overrides jump (and halt)
        stall = 1; jump = 1; jump_target = 10'h155; halt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) halt = 1;
            tick();
            chk("stall_pc", int'(pc), 'h005);
            chk("stall_count", int'(insn_count), 0);
            chk("stall_running", int'(running), 1);
        end
        stall = 0; halt = 0;
        tick();
        jump = 0;
        chk("unstall_pc", int'(pc), 'h155);
        chk("unstall_count", int'(insn_count), 1);

        // 6. start during RUN ignored; reset mid-RUN aborts
        start = 1; start_addr = 10'h200;
        tick();
        start = 0;
        chk("run_start_ignored", int'(pc), 'h156);
        do_jump('h123);
        branch = 1; flag = 1; offset = 8'h10; reset = 1;
        tick();
        reset = 0; branch = 0; flag = 0;
        chk("abort_pc", int'(pc), 0);
        chk("abort_running", int'(running), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_count", int'(insn_count), 0);

        // Counter saturation
        start = 1; start_addr = 10'h000;
        tick();
        start = 0;
        tick(CNT_MAX - 1);
        chk("count_fffe", int'(insn_count), 'hFFFE);
        tick(3);
        chk("count_sat", int'(insn_count), 'hFFFF);
        halt = 1;
        tick();
        halt = 0;
        chk("count_sat_halt", int'(insn_count), 'hFFFF);
        chk("sat_halt_done", int'(done), 1);

        tick();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
